// File: rtl/spi_master_sched_pkg.sv
// Shared SPI definitions: frame length and scheduler FSM states.
// Used by the SPI master scheduler and its sub-blocks.
package spi_master_sched_pkg;

    localparam int SPI_DATA_LENGTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_sched_rr_arbiter.sv
// Round-robin arbiter: first set request searching upward from ptr+1.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % N_REQ]) begin
                any = 1'b1;
                gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
                idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_master_sched.sv
// SPI mode-0 master shared round-robin between N_REQ requesters.
// One byte per SS frame, full duplex, all outputs registered.
module spi_master_sched
    import spi_master_sched_pkg::*;
#(
    parameter int  N_REQ    = 2,
    parameter int  DATA_W   = SPI_DATA_LENGTH,
    parameter int  CLK_DIV  = 4,
    parameter int  SS_SETUP = 2,
    parameter int  SS_GAP   = 4,
    localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      done,
    output logic [IW-1:0]             done_id,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      busy,
    output logic                      SCLK,
    output logic                      MOSI,
    input  logic                      MISO,
    output logic                      SS
);

    localparam int TW = $clog2(max3(CLK_DIV, SS_SETUP, SS_GAP));
    localparam int EW = $clog2(2 * DATA_W + 1);

    state_e              state_q, state_nx;
    logic [TW-1:0]       cnt_q, cnt_nx;
    logic [EW-1:0]       ecnt_q, ecnt_nx;
    logic [DATA_W-1:0]   tx_q, tx_nx;
    logic [DATA_W-1:0]   rx_q, rx_nx;
    logic [IW-1:0]       id_q, id_nx;
    logic [IW-1:0]       ptr_q, ptr_nx;
    logic [N_REQ-1:0]    gnt_nx;
    logic                done_nx, busy_nx, sclk_nx, mosi_nx, ss_nx;
    logic [IW-1:0]       done_id_nx;
    logic [DATA_W-1:0]   rx_data_nx;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_data = req_data[arb_idx*DATA_W +: DATA_W];

    always_comb begin
        state_nx   = state_q;
        cnt_nx     = cnt_q;
        ecnt_nx    = ecnt_q;
        tx_nx      = tx_q;
        rx_nx      = rx_q;
        id_nx      = id_q;
        ptr_nx     = ptr_q;
        gnt_nx     = '0;
        done_nx    = 1'b0;
        busy_nx    = busy;
        sclk_nx    = SCLK;
        mosi_nx    = MOSI;
        ss_nx      = SS;
        done_id_nx = done_id;
        rx_data_nx = rx_data;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_nx = ST_SETUP;
                    cnt_nx   = '0;
                    gnt_nx   = arb_gnt;
                    tx_nx    = sel_data;
                    id_nx    = arb_idx;
                    ptr_nx   = arb_idx;
                    ss_nx    = 1'b0;
                    mosi_nx  = sel_data[DATA_W-1];
                    busy_nx  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == TW'(SS_SETUP - 1)) begin
                    state_nx = ST_SHIFT;
                    cnt_nx   = '0;
                    ecnt_nx  = '0;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != TW'(CLK_DIV - 1)) begin
                    cnt_nx = cnt_q + 1'b1;
                end else begin
                    cnt_nx  = '0;
                    ecnt_nx = ecnt_q + 1'b1;
                    sclk_nx = !SCLK;
                    if (!SCLK) begin
                        rx_nx = {rx_q[DATA_W-2:0], MISO};
                    end else if (ecnt_q == EW'(2 * DATA_W - 1)) begin
                        state_nx   = ST_GAP;
                        ss_nx      = 1'b1;
                        done_nx    = 1'b1;
                        rx_data_nx = rx_q;
                        done_id_nx = id_q;
                    end else begin
                        // rotate so the next bit sits at the MSB
                        tx_nx   = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
                        mosi_nx = tx_q[DATA_W-2];
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == TW'(SS_GAP - 1)) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ecnt_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            id_q    <= '0;
            ptr_q   <= IW'(N_REQ - 1);
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            SS      <= 1'b1;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            ecnt_q  <= ecnt_nx;
            tx_q    <= tx_nx;
            rx_q    <= rx_nx;
            id_q    <= id_nx;
            ptr_q   <= ptr_nx;
            gnt     <= gnt_nx;
            done    <= done_nx;
            done_id <= done_id_nx;
            rx_data <= rx_data_nx;
            busy    <= busy_nx;
            SCLK    <= sclk_nx;
            MOSI    <= mosi_nx;
            SS      <= ss_nx;
        end
    end

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: behavioural mode-0 slave, timestamp model,
// vector table, hand sequences and randomized request traffic.
module tb_spi_master_sched;

    localparam int N_REQ    = 2;
    localparam int DATA_W   = 8;
    localparam int CLK_DIV  = 4;
    localparam int SS_SETUP = 2;
    localparam int SS_GAP   = 4;
    localparam int SS_LOW   = SS_SETUP + 2 * DATA_W * CLK_DIV;
    localparam int BUSY_LEN = SS_LOW + SS_GAP;
    localparam int PERIOD   = 1 + SS_LOW + SS_GAP;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        gnt;
    logic                    done;
    logic                    done_id;
    logic [DATA_W-1:0]       rx_data;
    logic                    busy;
    logic                    SCLK;
    logic                    MOSI;
    logic                    MISO;
    logic                    SS;

    spi_master_sched #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .CLK_DIV  (CLK_DIV),
        .SS_SETUP (SS_SETUP),
        .SS_GAP   (SS_GAP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .done_id  (done_id),
        .rx_data  (rx_data),
        .busy     (busy),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .SS       (SS)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Mode-0 slave: loads on SS fall, samples on rise, shifts on fall
    logic [7:0] s_tx = '0;
    logic [7:0] s_rx = '0;
    logic [7:0] slv_last = '0;
    logic [7:0] slv_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] got_q[$];

    assign MISO = SS ? 1'b0 : s_tx[7];

    always @(negedge SS) begin
        s_tx = (slv_q.size() > 0) ? slv_q.pop_front() : 8'($urandom);
        exp_rx_q.push_back(s_tx);
    end
    always @(posedge SCLK) if (!SS) s_rx = {s_rx[6:0], MOSI};
    always @(negedge SCLK) if (!SS) s_tx = {s_tx[6:0], 1'b0};
    always @(posedge SS) begin
        slv_last = s_rx;
        got_q.push_back(s_rx);
    end

    // Reference model: frame timing from grant timestamps
    typedef struct {
        int         id;
        logic [7:0] tx;
        int         due;
    } frame_t;
    frame_t           fq[$];
    int               cyc, m_ptr, last_g, sel, m_id;
    logic [N_REQ-1:0] m_gnt;
    logic             m_done, m_busy, m_ssl;
    logic [7:0]       m_tx;

    always @(posedge clk) begin
        if (!rst_n) begin
            cyc = 0; m_ptr = N_REQ - 1; last_g = -10000;
            fq.delete(); m_gnt = '0; m_done = 0; m_busy = 0; m_ssl = 0;
        end else begin
            cyc++;
            m_gnt = '0;
            m_done = 0;
            if (cyc >= last_g + PERIOD && req != '0) begin
                sel = -1;
                for (int k = 1; k <= N_REQ; k++)
                    if (sel < 0 && req[(m_ptr + k) % N_REQ])
                        sel = (m_ptr + k) % N_REQ;
                m_gnt[sel] = 1'b1;
                m_ptr = sel;
                last_g = cyc;
                fq.push_back('{sel, req_data[sel*DATA_W +: DATA_W], cyc + SS_LOW});
            end
            m_busy = (cyc - last_g) < BUSY_LEN;
            m_ssl  = (cyc - last_g) < SS_LOW;
            if (fq.size() > 0 && fq[0].due == cyc) begin
                m_done = 1;
                m_id = fq[0].id;
                m_tx = fq[0].tx;
                void'(fq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rx_q.delete();
            got_q.delete();
        end else begin
            chk("model_gnt", gnt, m_gnt);
            chk("model_done", done, m_done);
            chk("model_busy", busy, m_busy);
            chk("model_ss", SS, !m_ssl);
            if (m_done) begin
                chk("model_slave_frame",
                    (exp_rx_q.size() != 0 && got_q.size() != 0), 1'b1);
                if (exp_rx_q.size() != 0 && got_q.size() != 0) begin
                    chk("model_done_id", done_id, m_id);
                    chk("model_rx_data", rx_data, exp_rx_q.pop_front());
                    chk("model_slave_rx", got_q.pop_front(), m_tx);
                end
            end
        end
    end

    // Frame monitor: SS low/high lengths and SCLK rises per frame
    int   lowcnt = 0, rises = 0, highcnt = 0;
    int   last_low = 0, last_rises = 0, last_high = 0;
    logic prev_ss = 1'b1, prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!SS) begin
            if (prev_ss) begin
                last_high = highcnt; lowcnt = 0; rises = 0;
            end
            lowcnt++;
            if (SCLK && !prev_sclk) rises++;
        end else begin
            if (!prev_ss) begin
                last_low = lowcnt; last_rises = rises; highcnt = 0;
            end
            highcnt++;
        end
        prev_ss = SS;
        prev_sclk = SCLK;
    end

    task automatic wait_gnt(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (gnt != '0) ok = 1;
        end
        chk({nm, "_gnt_seen"}, ok, 1'b1);
    endtask

    task automatic wait_done(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            if (done) ok = 1;
        end
        chk({nm, "_done_seen"}, ok, 1'b1);
    endtask

    typedef struct {
        logic [1:0] rq;
        logic [7:0] d0, d1, slv;
        int         exp_id;
        logic [7:0] exp_slv;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{2'b01, 8'hA5, 8'h00, 8'h3C, 0, 8'hA5};
        tbl[1] = '{2'b01, 8'h80, 8'h00, 8'h01, 0, 8'h80};
        tbl[2] = '{2'b10, 8'h00, 8'hC3, 8'hFF, 1, 8'hC3};
        tbl[3] = '{2'b11, 8'h11, 8'h22, 8'h5A, 0, 8'h11};
        tbl[4] = '{2'b11, 8'h11, 8'h22, 8'h96, 1, 8'h22};
        tbl[5] = '{2'b11, 8'h11, 8'h22, 8'h0F, 0, 8'h11};
        tbl[6] = '{2'b10, 8'h00, 8'h00, 8'h00, 1, 8'h00};
        tbl[7] = '{2'b01, 8'hFF, 8'h00, 8'hAA, 0, 8'hFF};

        repeat (3) @(negedge clk);
        chk("rst_ss", SS, 1'b1);
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_done_id", done_id, 1'b0);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            req_data = {tbl[v].d1, tbl[v].d0};
            slv_q.push_back(tbl[v].slv);
            req = tbl[v].rq;
            wait_gnt("tbl");
            chk("tbl_gnt", gnt, 32'(1) << tbl[v].exp_id);
            req = '0;
            wait_done("tbl");
            chk("tbl_done_id", done_id, tbl[v].exp_id);
            chk("tbl_rx_data", rx_data, tbl[v].slv);
            chk("tbl_slave_rx", slv_last, tbl[v].exp_slv);
            chk("tbl_ss_low", last_low, SS_LOW);
            chk("tbl_sclk_pulses", last_rises, DATA_W);
        end

        // back-to-back frames from one held request
        @(negedge clk);
        req_data[7:0] = 8'h00;
        slv_q.push_back(8'h3C);
        slv_q.push_back(8'hC3);
        req = 2'b01;
        wait_gnt("b2b1");
        req_data[7:0] = 8'hFF;
        wait_done("b2b1");
        chk("b2b1_rx", rx_data, 8'h3C);
        chk("b2b1_slave", slv_last, 8'h00);
        wait_gnt("b2b2");
        chk("b2b_ss_gap", last_high, SS_GAP + 1);
        req = '0;
        wait_done("b2b2");
        chk("b2b2_rx", rx_data, 8'hC3);
        chk("b2b2_slave", slv_last, 8'hFF);

        // reset in the middle of SHIFT
        @(negedge clk);
        req_data[7:0] = 8'h33;
        slv_q.push_back(8'h99);
        req = 2'b01;
        wait_gnt("mid");
        req = '0;
        begin
            bit ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk); #1;
                if (rises >= 3 && SCLK) ok = 1;
            end
            chk("mid_third_rise", ok, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ss", SS, 1'b1);
        chk("mid_rst_sclk", SCLK, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("mid_rst_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        req_data[7:0] = 8'h5A;
        slv_q.push_back(8'hA5);
        req = 2'b01;
        wait_gnt("post");
        chk("post_gnt", gnt, 2'b01);
        req = '0;
        wait_done("post");
        chk("post_done_id", done_id, 1'b0);
        chk("post_rx", rx_data, 8'hA5);
        chk("post_slave", slv_last, 8'h5A);
        chk("post_ss_low", last_low, SS_LOW);
        chk("post_sclk_pulses", last_rises, DATA_W);

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 3500; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(3) != 0)
                        req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                    else
                        req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                    req[i] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (PERIOD + 10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
